// File: rtl/lut_arb2_if.sv
// lut_arb2_if -- command and result bundle for the two-channel LCD lookup table.
//
// Signals
//   arw/add/awdata/a_ready : channel A command (2'b10 read, 2'b01 write), address,
//                            write data and accept strobe
//   brw/bdd/bwdata/b_ready : channel B, same meaning as channel A
//   z/z_valid/z_src/z_err  : registered lookup result, valid flag, source channel
//                            (0 = A, 1 = B) and out-of-range flag
//   z_ready                : downstream consumes z when z_valid && z_ready
//
// Modports
//   master : requester/consumer side (drives commands and z_ready)
//   slave  : lookup table side (drives readies and the result)
interface lut_arb2_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [1:0]        arw;
  logic [ADDR_W-1:0] add;
  logic [DATA_W-1:0] awdata;
  logic              a_ready;
  logic [1:0]        brw;
  logic [ADDR_W-1:0] bdd;
  logic [DATA_W-1:0] bwdata;
  logic              b_ready;
  logic [DATA_W-1:0] z;
  logic              z_valid;
  logic              z_src;
  logic              z_err;
  logic              z_ready;

  modport master (
    output arw, add, awdata, brw, bdd, bwdata, z_ready,
    input  a_ready, b_ready, z, z_valid, z_src, z_err
  );

  modport slave (
    input  arw, add, awdata, brw, bdd, bwdata, z_ready,
    output a_ready, b_ready, z, z_valid, z_src, z_err
  );
endinterface

// File: rtl/lut_arb2.sv
// lut_arb2 -- two-channel lookup table for the LCD display path.
//
// Each channel owns a writable table bank. Both channels share one registered,
// back-pressured result register. One command is granted per cycle; reads need
// the result slot to be free, writes do not.
//
// Ports
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (banks back to defaults, result dropped)
//   bus  : lut_arb2_if.slave -- channel commands/readies and the result stream
//
// Build option
//   ROUND_ROBIN_EN : when defined, a last-grant pointer breaks A/B ties in favour
//                    of the channel not granted last. When undefined, channel A
//                    always has priority and the pointer does not exist.
module lut_arb2 #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int DEPTH_A = 16,
  parameter int DEPTH_B = 16
) (
  input logic     clk,
  input logic     rst,
  lut_arb2_if.slave bus
);

  localparam int IW_A = (DEPTH_A > 1) ? $clog2(DEPTH_A) : 1;
  localparam int IW_B = (DEPTH_B > 1) ? $clog2(DEPTH_B) : 1;

  // Default contents, one nibble per entry, entry 0 in the least significant nibble.
  localparam logic [63:0] DEF_A = 64'h3501_4064_4604_1053;
  localparam logic [63:0] DEF_B = 64'h0000_0001_3105_0131;

  // Reset value of entry idx; entries past the 16-entry default table are zero.
  function automatic logic [DATA_W-1:0] def_entry(input logic [63:0] tbl, input int idx);
    logic [DATA_W-1:0] val;
    logic [3:0]        nib_idx;
    val     = '0;
    nib_idx = idx[3:0];
    if (idx < 32'sd16) begin
      val = DATA_W'(tbl[{nib_idx, 2'b00} +: 4]);
    end else begin
      val = '0;
    end
    return val;
  endfunction

  logic [DATA_W-1:0] bank_a_r [DEPTH_A];
  logic [DATA_W-1:0] bank_b_r [DEPTH_B];

  logic [DATA_W-1:0] z_r;
  logic              z_valid_r;
  logic              z_src_r;
  logic              z_err_r;

  logic              req_a_s, rd_a_s, ok_a_s, gnt_a_s, in_a_s;
  logic              req_b_s, rd_b_s, ok_b_s, gnt_b_s, in_b_s;
  logic              slot_free_s;
  logic              rd_grant_s;
  logic [IW_A-1:0]   idx_a_s;
  logic [IW_B-1:0]   idx_b_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              rd_err_s;

`ifdef ROUND_ROBIN_EN
  logic              ptr_r;   // last granted channel: 0 = A, 1 = B
`endif

  assign idx_a_s = bus.add[IW_A-1:0];
  assign idx_b_s = bus.bdd[IW_B-1:0];
  assign in_a_s  = ({1'b0, bus.add} < (ADDR_W+1)'(DEPTH_A));
  assign in_b_s  = ({1'b0, bus.bdd} < (ADDR_W+1)'(DEPTH_B));

  // Request decode and single-grant arbitration.
  always_comb begin
    req_a_s     = (bus.arw == 2'b10) || (bus.arw == 2'b01);
    rd_a_s      = (bus.arw == 2'b10);
    req_b_s     = (bus.brw == 2'b10) || (bus.brw == 2'b01);
    rd_b_s      = (bus.brw == 2'b10);
    slot_free_s = !z_valid_r || bus.z_ready;
    // A read is only grantable when the result slot can take it; a blocked
    // A read must not stop a B write.
    ok_a_s      = req_a_s && (!rd_a_s || slot_free_s);
    ok_b_s      = req_b_s && (!rd_b_s || slot_free_s);
    gnt_a_s     = 1'b0;
    gnt_b_s     = 1'b0;
`ifdef ROUND_ROBIN_EN
    if (ok_a_s && ok_b_s) begin
      gnt_a_s = ptr_r;
      gnt_b_s = !ptr_r;
    end else begin
      gnt_a_s = ok_a_s;
      gnt_b_s = ok_b_s;
    end
`else
    gnt_a_s = ok_a_s;
    gnt_b_s = ok_b_s && !ok_a_s;
`endif
    rd_grant_s = (gnt_a_s && rd_a_s) || (gnt_b_s && rd_b_s);
  end

  // Read data mux for the granted channel; out-of-range reads return zero with an error.
  always_comb begin
    rd_data_s = '0;
    rd_err_s  = 1'b0;
    if (gnt_a_s) begin
      if (in_a_s) begin
        rd_data_s = bank_a_r[idx_a_s];
        rd_err_s  = 1'b0;
      end else begin
        rd_data_s = '0;
        rd_err_s  = 1'b1;
      end
    end else begin
      if (in_b_s) begin
        rd_data_s = bank_b_r[idx_b_s];
        rd_err_s  = 1'b0;
      end else begin
        rd_data_s = '0;
        rd_err_s  = 1'b1;
      end
    end
  end

  // Table banks, result register and arbitration pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_A; i++) begin
        bank_a_r[i] <= def_entry(DEF_A, i);
      end
      for (int i = 0; i < DEPTH_B; i++) begin
        bank_b_r[i] <= def_entry(DEF_B, i);
      end
      z_r       <= '0;
      z_valid_r <= 1'b0;
      z_src_r   <= 1'b0;
      z_err_r   <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptr_r     <= 1'b0;
`endif
    end else begin
      // Out-of-range writes are dropped without any response.
      if (gnt_a_s && !rd_a_s && in_a_s) begin
        bank_a_r[idx_a_s] <= bus.awdata;
      end
      if (gnt_b_s && !rd_b_s && in_b_s) begin
        bank_b_r[idx_b_s] <= bus.bwdata;
      end
      if (rd_grant_s) begin
        z_r       <= rd_data_s;
        z_valid_r <= 1'b1;
        z_src_r   <= gnt_b_s;
        z_err_r   <= rd_err_s;
      end else if (z_valid_r && bus.z_ready) begin
        // Consumed with nothing new: data fields keep their last value.
        z_valid_r <= 1'b0;
      end
`ifdef ROUND_ROBIN_EN
      if (gnt_a_s) begin
        ptr_r <= 1'b0;
      end else if (gnt_b_s) begin
        ptr_r <= 1'b1;
      end
`endif
    end
  end

  assign bus.a_ready = gnt_a_s;
  assign bus.b_ready = gnt_b_s;
  assign bus.z       = z_r;
  assign bus.z_valid = z_valid_r;
  assign bus.z_src   = z_src_r;
  assign bus.z_err   = z_err_r;

endmodule

// File: tb/tb_lut_arb2.sv
// tb_lut_arb2 -- directed self-checking bench for lut_arb2 (default parameters).
// Expected read results are pushed to a scoreboard queue when a read is granted
// and popped when the result register updates.
module tb_lut_arb2;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lut_arb2_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  lut_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_A(16), .DEPTH_B(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] def_a [16] = '{8'd3, 8'd5, 8'd0, 8'd1, 8'd4, 8'd0, 8'd6, 8'd4,
                             8'd4, 8'd6, 8'd0, 8'd4, 8'd1, 8'd0, 8'd5, 8'd3};
  logic [7:0] def_b [16] = '{8'd1, 8'd3, 8'd1, 8'd0, 8'd5, 8'd0, 8'd1, 8'd3,
                             8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] ma [16];
  logic [7:0] mb [16];
  logic       mv;      // model of z_valid
  logic       last;    // last granted channel
  logic [9:0] sb [$];  // {src, err, data}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      ma[i] = def_a[i];
      mb[i] = def_b[i];
    end
    mv   = 1'b0;
    last = 1'b0;
    sb.delete();
  endtask

  task automatic idle_inputs();
    bus.arw = 2'b00; bus.add = '0; bus.awdata = '0;
    bus.brw = 2'b00; bus.bdd = '0; bus.bwdata = '0;
    bus.z_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_z", bus.z, 32'h0);
    chk("rst_z_valid", bus.z_valid, 32'h0);
    chk("rst_z_src", bus.z_src, 32'h0);
    chk("rst_z_err", bus.z_err, 32'h0);
  endtask

  // One clock: drive commands, check readies, clock, check the result.
  task automatic cyc(input logic [1:0] a_cmd, input logic [4:0] a_ad, input logic [7:0] a_wd,
                     input logic [1:0] b_cmd, input logic [4:0] b_ad, input logic [7:0] b_wd,
                     input logic zr);
    logic rda, rdb, oka, okb, slot, ga, gb, rdg;
    logic [9:0] e;
    bus.arw = a_cmd; bus.add = a_ad; bus.awdata = a_wd;
    bus.brw = b_cmd; bus.bdd = b_ad; bus.bwdata = b_wd;
    bus.z_ready = zr;
    #1;
    rda  = (a_cmd == 2'b10);
    rdb  = (b_cmd == 2'b10);
    slot = !mv || zr;
    oka  = (a_cmd == 2'b10 || a_cmd == 2'b01) && (!rda || slot);
    okb  = (b_cmd == 2'b10 || b_cmd == 2'b01) && (!rdb || slot);
`ifdef ROUND_ROBIN_EN
    if (oka && okb) begin ga = last; gb = !last; end
    else begin ga = oka; gb = okb; end
`else
    ga = oka;
    gb = okb && !oka;
`endif
    chk("a_ready", bus.a_ready, ga);
    chk("b_ready", bus.b_ready, gb);
    rdg = 1'b0;
    if (ga) begin
      last = 1'b0;
      if (rda) begin
        rdg = 1'b1;
        sb.push_back((a_ad < 5'd16) ? {1'b0, 1'b0, ma[a_ad[3:0]]} : {1'b0, 1'b1, 8'h00});
      end else if (a_ad < 5'd16) begin
        ma[a_ad[3:0]] = a_wd;
      end
    end
    if (gb) begin
      last = 1'b1;
      if (rdb) begin
        rdg = 1'b1;
        sb.push_back((b_ad < 5'd16) ? {1'b1, 1'b0, mb[b_ad[3:0]]} : {1'b1, 1'b1, 8'h00});
      end else if (b_ad < 5'd16) begin
        mb[b_ad[3:0]] = b_wd;
      end
    end
    if (rdg) mv = 1'b1;
    else if (mv && zr) mv = 1'b0;
    @(posedge clk); #1;
    chk("z_valid", bus.z_valid, mv);
    if (rdg) begin
      e = sb.pop_front();
      chk("z", bus.z, e[7:0]);
      chk("z_err", bus.z_err, e[8]);
      chk("z_src", bus.z_src, e[9]);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Basic reads from both banks, including the range boundary.
    cyc(2'b10, 5'd1, 8'h00, 2'b00, 5'd0, 8'h00, 1'b1);
    chk("a_read1", bus.z, 32'h5);
    cyc(2'b00, 5'd0, 8'h00, 2'b10, 5'd4, 8'h00, 1'b1);
    chk("b_read4_src", bus.z_src, 32'h1);
    cyc(2'b00, 5'd0, 8'h00, 2'b10, 5'd12, 8'h00, 1'b1);
    cyc(2'b00, 5'd0, 8'h00, 2'b10, 5'd16, 8'h00, 1'b1);
    chk("b_read16_err", bus.z_err, 32'h1);

    // Write then read-after-write; out-of-range write is dropped.
    cyc(2'b01, 5'd3, 8'hA5, 2'b00, 5'd0, 8'h00, 1'b1);
    cyc(2'b10, 5'd3, 8'h00, 2'b00, 5'd0, 8'h00, 1'b1);
    chk("raw_a3", bus.z, 32'hA5);
    cyc(2'b01, 5'd20, 8'h77, 2'b00, 5'd0, 8'h00, 1'b1);
    cyc(2'b10, 5'd20, 8'h00, 2'b00, 5'd0, 8'h00, 1'b1);

    // Reset restores the default table.
    do_reset();
    cyc(2'b10, 5'd3, 8'h00, 2'b00, 5'd0, 8'h00, 1'b1);
    chk("after_rst_a3", bus.z, 32'h1);

    // Both channels reading every cycle.
    for (int k = 0; k < 4; k++) begin
      cyc(2'b10, 5'(k), 8'h00, 2'b10, 5'(k + 4), 8'h00, 1'b1);
    end

    // Backpressure: reads blocked, B write still accepted, stable output.
    cyc(2'b10, 5'd0, 8'h00, 2'b00, 5'd0, 8'h00, 1'b1);
    cyc(2'b10, 5'd1, 8'h00, 2'b01, 5'd2, 8'h77, 1'b0);
    chk("bp_a_blocked_z", bus.z, 32'h3);
    cyc(2'b10, 5'd1, 8'h00, 2'b10, 5'd2, 8'h00, 1'b0);
    chk("bp_hold_z", bus.z, 32'h3);
    chk("bp_hold_src", bus.z_src, 32'h0);
    cyc(2'b10, 5'd1, 8'h00, 2'b00, 5'd0, 8'h00, 1'b1);
    chk("bp_release_z", bus.z, 32'h5);
    cyc(2'b00, 5'd0, 8'h00, 2'b10, 5'd2, 8'h00, 1'b1);
    chk("bp_b_write_seen", bus.z, 32'h77);
    // Consume with no new read: valid drops, data holds.
    cyc(2'b00, 5'd0, 8'h00, 2'b00, 5'd0, 8'h00, 1'b1);
    chk("consume_hold_z", bus.z, 32'h77);
    chk("consume_hold_src", bus.z_src, 32'h1);

    // Reset while a result is pending and another read is waiting.
    cyc(2'b10, 5'd6, 8'h00, 2'b00, 5'd0, 8'h00, 1'b1);
    bus.arw = 2'b10; bus.add = 5'd7; bus.z_ready = 1'b0;
    #1;
    chk("pre_rst_valid", bus.z_valid, 32'h1);
    chk("pre_rst_a_ready", bus.a_ready, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("midrst_z_valid", bus.z_valid, 32'h0);
    chk("midrst_z", bus.z, 32'h0);
    cyc(2'b00, 5'd0, 8'h00, 2'b10, 5'd2, 8'h00, 1'b1);
    chk("midrst_b2_default", bus.z, 32'h1);
    cyc(2'b10, 5'd3, 8'h00, 2'b00, 5'd0, 8'h00, 1'b1);
    chk("midrst_a3_default", bus.z, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
